intr_multi: RTL



---
 rtl/intr_pkg.sv | 19 +
 rtl/intr_arb.sv | 30 +++
 rtl/intr_multi.sv | 136 +++++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the vc32 multi-source interrupt controller:
// register offsets, claim word layout and the priority type.
package intr_pkg;

  localparam int unsigned NSRC_MAX        = 16;
  localparam int unsigned CLAIM_VALID_BIT = 15;

  localparam logic [3:0] ADDR_PENDING    = 4'd0;
  localparam logic [3:0] ADDR_ENABLE     = 4'd1;
  localparam logic [3:0] ADDR_MODE       = 4'd2;
  localparam logic [3:0] ADDR_CLAIM      = 4'd3;
  localparam logic [3:0] ADDR_PRIO_LO    = 4'd4;
  localparam logic [3:0] ADDR_PRIO_HI    = 4'd5;
  localparam logic [3:0] ADDR_THRESHOLD  = 4'd6;
  localparam logic [3:0] ADDR_IN_SERVICE = 4'd7;

  typedef logic [1:0] prio_t;

endpackage

// File: rtl/intr_arb.sv
// Combinational winner select: highest priority eligible source,
// ties resolved towards the lowest index.
module intr_arb
  import intr_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic  [NSRC-1:0] eligible,
  input  prio_t [NSRC-1:0] prio,
  output logic             valid,
  output logic  [3:0]      id
);

  prio_t best;

  // Strict '>' keeps the earlier (lower) index on equal priority
  always_comb begin
    valid = 1'b0;
    id    = '0;
    best  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i] && (!valid || (prio[i] > best))) begin
        valid = 1'b1;
        id    = 4'(i);
        best  = prio[i];
      end
    end
  end

endmodule

// File: rtl/intr_multi.sv
// NSRC-source interrupt controller on the 16-bit I/O bus with priority,
// threshold and claim/complete in-service masking.
module intr_multi
  import intr_pkg::*;
#(
  parameter int unsigned NSRC = 8,
  parameter int unsigned RV   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [3:0]      io_addr,
  input  logic            io_write,
  input  logic            io_read,
  input  logic [RV-1:0]   io_wdata,
  output logic [RV-1:0]   io_rdata,
  output logic            interrupt
);

  logic  [NSRC-1:0] src_q;
  logic  [NSRC-1:0] pending,    pending_n;
  logic  [NSRC-1:0] enable,     enable_n;
  logic  [NSRC-1:0] mode,       mode_n;
  logic  [NSRC-1:0] in_service, in_service_n;
  prio_t [NSRC-1:0] prio_q,     prio_n;
  prio_t            threshold,  threshold_n;

  logic  [NSRC-1:0] eligible;
  logic             arb_valid;
  logic  [3:0]      arb_id;

  logic             claim;
  logic             wr_pending, wr_complete;
  logic [2*NSRC_MAX-1:0] prio_all;

  intr_arb #(.NSRC(NSRC)) u_arb (
    .eligible (eligible),
    .prio     (prio_q),
    .valid    (arb_valid),
    .id       (arb_id)
  );

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NSRC; i++) begin
      eligible[i] = pending[i] & enable[i] & ~in_service[i] & (prio_q[i] > threshold);
    end
  end

  assign claim       = io_read  && (io_addr == ADDR_CLAIM) && arb_valid;
  assign wr_pending  = io_write && (io_addr == ADDR_PENDING);
  assign wr_complete = io_write && (io_addr == ADDR_CLAIM);

  // Next-state for all programmable and status registers
  always_comb begin
    logic hold;
    hold         = 1'b0;
    pending_n    = pending;
    enable_n     = enable;
    mode_n       = mode;
    in_service_n = in_service;
    prio_n       = prio_q;
    threshold_n  = threshold;

    for (int i = 0; i < NSRC; i++) begin
      if (mode[i]) begin
        // Edge mode: a new rising edge beats any clear in the same cycle
        hold = pending[i];
        if (wr_pending && io_wdata[i]) hold = 1'b0;
        if (claim && (arb_id == 4'(i))) hold = 1'b0;
        pending_n[i] = hold | (src[i] & ~src_q[i]);
      end else begin
        pending_n[i] = src[i];
      end

      if (claim && (arb_id == 4'(i))) in_service_n[i] = 1'b1;
      if (wr_complete && (io_wdata[3:0] == 4'(i))) in_service_n[i] = 1'b0;

      if (io_write && (io_addr == ADDR_PRIO_LO) && (i < 8))
        prio_n[i] = io_wdata[2*(i%8) +: 2];
      if (io_write && (io_addr == ADDR_PRIO_HI) && (i >= 8))
        prio_n[i] = io_wdata[2*(i%8) +: 2];
    end

    if (io_write && (io_addr == ADDR_ENABLE))    enable_n    = io_wdata[NSRC-1:0];
    if (io_write && (io_addr == ADDR_MODE))      mode_n      = io_wdata[NSRC-1:0];
    if (io_write && (io_addr == ADDR_THRESHOLD)) threshold_n = io_wdata[1:0];
  end

  // src_q tracks src through reset so a line already high is not an edge
  always_ff @(posedge clk) begin
    src_q <= src;
    if (reset) begin
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      in_service <= '0;
      prio_q     <= '0;
      threshold  <= '0;
      interrupt  <= 1'b0;
    end else begin
      pending    <= pending_n;
      enable     <= enable_n;
      mode       <= mode_n;
      in_service <= in_service_n;
      prio_q     <= prio_n;
      threshold  <= threshold_n;
      interrupt  <= arb_valid;
    end
  end

  // Combinational read mux
  always_comb begin
    prio_all = '0;
    for (int i = 0; i < NSRC; i++) prio_all[2*i +: 2] = prio_q[i];

    io_rdata = '0;
    case (io_addr)
      ADDR_PENDING:    io_rdata = RV'(pending);
      ADDR_ENABLE:     io_rdata = RV'(enable);
      ADDR_MODE:       io_rdata = RV'(mode);
      ADDR_CLAIM: begin
        if (arb_valid) begin
          io_rdata[CLAIM_VALID_BIT] = 1'b1;
          io_rdata[3:0]             = arb_id;
        end
      end
      ADDR_PRIO_LO:    io_rdata = prio_all[15:0];
      ADDR_PRIO_HI:    io_rdata = prio_all[31:16];
      ADDR_THRESHOLD:  io_rdata = RV'(threshold);
      ADDR_IN_SERVICE: io_rdata = RV'(in_service);
      default:         io_rdata = '0;
    endcase
  end

endmodule
